// File: rtl/arcade_input_cond.sv
// Input conditioner for arcade cores: sync + debounce of active-low pins, keyboard merge,
// press/release edges, fixed-width coin pulse and a hold-to-cycle scanline combo.
module arcade_input_cond #(
  parameter int unsigned        NUM_CH     = 8,
  parameter int unsigned        DEB_BITS   = 10,
  parameter int unsigned        COIN_CH    = 5,
  parameter int unsigned        COIN_PULSE = 16,
  parameter logic [NUM_CH-1:0]  COMBO_MASK = 8'b0110_0000,
  parameter int unsigned        COMBO_BITS = 20
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_n_i,
  input  logic [NUM_CH-1:0] kbd_i,
  output logic [NUM_CH-1:0] btn_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic              coin_o,
  output logic              combo_o,
  output logic [1:0]        scanlines_o
);

  localparam int unsigned CoinW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [CoinW-1:0] CoinLoad = CoinW'(COIN_PULSE - 1);

  typedef enum logic [1:0] {StIdle, StArming, StFired} combo_state_e;

  logic [NUM_CH-1:0]   sync1_q, sync2_q;
  logic [NUM_CH-1:0]   st_q, st_d;
  logic [DEB_BITS-1:0] cnt_q [NUM_CH];
  logic [DEB_BITS-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   btn_q, prev_q, press_q, release_q;

  logic                coin_q, coin_d;
  logic [CoinW-1:0]    coin_cnt_q, coin_cnt_d;

  combo_state_e        state_q, state_d;
  logic [COMBO_BITS-1:0] timer_q, timer_d;
  logic                combo_q, combo_d;
  logic [1:0]          scan_q, scan_d;
  logic                combo_all;

  // Debounce: a state change is accepted on the 2^DEB_BITS-th consecutive differing sample.
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != st_q[i]) begin
        if (&cnt_q[i]) begin
          st_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    coin_d     = coin_q;
    coin_cnt_d = coin_cnt_q;
    if (coin_q) begin
      if (coin_cnt_q == '0) begin
        coin_d = 1'b0;
      end else begin
        coin_cnt_d = coin_cnt_q - 1'b1;
      end
    end else if (press_q[COIN_CH]) begin
      coin_d     = 1'b1;
      coin_cnt_d = CoinLoad;
    end
  end

  assign combo_all = &(btn_q | ~COMBO_MASK);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    combo_d = 1'b0;
    scan_d  = scan_q;
    unique case (state_q)
      StIdle: begin
        if (combo_all) begin
          state_d = StArming;
          timer_d = '0;
        end
      end
      StArming: begin
        if (!combo_all) begin
          state_d = StIdle;
        end else if (&timer_q) begin
          state_d = StFired;
          combo_d = 1'b1;
          scan_d  = scan_q + 2'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFired: begin
        if (!combo_all) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      st_q       <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
      btn_q      <= '0;
      prev_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      coin_q     <= 1'b0;
      coin_cnt_q <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
      combo_q    <= 1'b0;
      scan_q     <= 2'd0;
    end else begin
      sync1_q    <= ~raw_n_i;
      sync2_q    <= sync1_q;
      st_q       <= st_d;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
      btn_q      <= st_q | kbd_i;
      prev_q     <= btn_q;
      press_q    <= btn_q & ~prev_q;
      release_q  <= ~btn_q & prev_q;
      coin_q     <= coin_d;
      coin_cnt_q <= coin_cnt_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      combo_q    <= combo_d;
      scan_q     <= scan_d;
    end
  end

  assign btn_o       = btn_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign coin_o      = coin_q;
  assign combo_o     = combo_q;
  assign scanlines_o = scan_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with short debounce/combo timers.
module tb_arcade_input_cond;

  logic       clk_sys;
  logic       reset;
  logic [7:0] raw_n_i;
  logic [7:0] kbd_i;
  logic [7:0] btn_o, press_o, release_o;
  logic       coin_o, combo_o;
  logic [1:0] scanlines_o;

  int checks   = 0;
  int failures = 0;

  arcade_input_cond #(
    .NUM_CH     (8),
    .DEB_BITS   (4),
    .COIN_CH    (5),
    .COIN_PULSE (16),
    .COMBO_MASK (8'h60),
    .COMBO_BITS (6)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .raw_n_i     (raw_n_i),
    .kbd_i       (kbd_i),
    .btn_o       (btn_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .coin_o      (coin_o),
    .combo_o     (combo_o),
    .scanlines_o (scanlines_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] kbd;
    logic [7:0] btn;
    logic [7:0] press;
    logic [7:0] rel;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_btn"}, 32'(btn_o), 32'd0);
    check({name, "_press"}, 32'(press_o), 32'd0);
    check({name, "_release"}, 32'(release_o), 32'd0);
    check({name, "_coin"}, 32'(coin_o), 32'd0);
    check({name, "_combo"}, 32'(combo_o), 32'd0);
    check({name, "_scan"}, 32'(scanlines_o), 32'd0);
  endtask

  // Hold kbd[6:5] for hold cycles; if rel_at > 0, drop bit 5 after that many cycles.
  task automatic combo_hold(input int hold, input int rel_at, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    kbd_i  = 8'h60;
    for (int c = 1; c <= hold; c++) begin
      if (rel_at > 0 && c > rel_at) kbd_i = 8'h40;
      tick();
      if (combo_o === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    kbd_i = 8'h00;
    repeat (5) tick();
  endtask

  initial begin
    int first_btn, first_edge, edges, hi, rises, pulses, first;
    logic prev;

    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'h08, 8'h08, 8'h00, 8'h00};
    vecs[2]  = '{8'h00, 8'h00, 8'h08, 8'h00};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 8'h08};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{8'h09, 8'h09, 8'h00, 8'h00};
    vecs[6]  = '{8'h09, 8'h09, 8'h09, 8'h00};
    vecs[7]  = '{8'h01, 8'h01, 8'h00, 8'h00};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 8'h08};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h01};
    vecs[10] = '{8'h82, 8'h82, 8'h00, 8'h00};
    vecs[11] = '{8'h80, 8'h80, 8'h82, 8'h00};
    vecs[12] = '{8'h00, 8'h00, 8'h00, 8'h02};
    vecs[13] = '{8'h00, 8'h00, 8'h00, 8'h80};
    vecs[14] = '{8'h00, 8'h00, 8'h00, 8'h00};

    reset   = 1'b1;
    raw_n_i = 8'hff;
    kbd_i   = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) tick();
    check_all_zero("post_reset_idle");

    // Keyboard path: 1-cycle latency, edges one cycle after btn_o.
    foreach (vecs[i]) begin
      kbd_i = vecs[i].kbd;
      tick();
      check($sformatf("vec%0d_btn", i), 32'(btn_o), 32'(vecs[i].btn));
      check($sformatf("vec%0d_press", i), 32'(press_o), 32'(vecs[i].press));
      check($sformatf("vec%0d_release", i), 32'(release_o), 32'(vecs[i].rel));
    end

    // Pin press on channel 0: btn after 19 cycles, press pulse at 20.
    raw_n_i   = 8'hfe;
    first_btn = 0; first_edge = 0; edges = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (btn_o[0] === 1'b1 && first_btn == 0) first_btn = c;
      if (press_o[0] === 1'b1) begin
        edges++;
        if (first_edge == 0) first_edge = c;
      end
    end
    check("deb_press_btn_latency", 32'(first_btn), 32'd19);
    check("deb_press_pulse_cycle", 32'(first_edge), 32'd20);
    check("deb_press_pulse_count", 32'(edges), 32'd1);

    raw_n_i   = 8'hff;
    first_btn = 0; first_edge = 0; edges = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (btn_o[0] === 1'b0 && first_btn == 0) first_btn = c;
      if (release_o[0] === 1'b1) begin
        edges++;
        if (first_edge == 0) first_edge = c;
      end
    end
    check("deb_release_btn_latency", 32'(first_btn), 32'd19);
    check("deb_release_pulse_cycle", 32'(first_edge), 32'd20);
    check("deb_release_pulse_count", 32'(edges), 32'd1);

    // Glitch: 15 low, 1 high, 15 low must never be accepted.
    hi = 0; edges = 0;
    for (int c = 1; c <= 60; c++) begin
      raw_n_i = (c <= 15 || (c >= 17 && c <= 31)) ? 8'hfe : 8'hff;
      tick();
      if (btn_o[0] !== 1'b0) hi++;
      if (press_o[0] !== 1'b0) edges++;
    end
    check("glitch_btn_high_cycles", 32'(hi), 32'd0);
    check("glitch_press_count", 32'(edges), 32'd0);

    // Coin: press, release, press again during the pulse -> one 16-cycle pulse.
    hi = 0; rises = 0; first = 0; prev = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      kbd_i = ((c <= 2) || (c >= 8 && c <= 9)) ? 8'h20 : 8'h00;
      tick();
      if (coin_o === 1'b1) begin
        hi++;
        if (first == 0) first = c;
        if (!prev) rises++;
      end
      prev = coin_o;
    end
    check("coin_width", 32'(hi), 32'd16);
    check("coin_rises", 32'(rises), 32'd1);
    check("coin_start", 32'(first), 32'd3);

    // Combo cycles scanlines 0->1->2->3->0.
    for (int k = 1; k <= 4; k++) begin
      combo_hold(200, 0, pulses, first);
      check($sformatf("combo%0d_pulses", k), 32'(pulses), 32'd1);
      check_range($sformatf("combo%0d_time", k), first, 64, 68);
      check($sformatf("combo%0d_scan", k), 32'(scanlines_o), 32'(k % 4));
    end

    combo_hold(100, 40, pulses, first);
    check("combo_abort_pulses", 32'(pulses), 32'd0);
    check("combo_abort_scan", 32'(scanlines_o), 32'd0);

    combo_hold(200, 0, pulses, first);
    combo_hold(200, 0, pulses, first);
    check("combo_pre_reset_scan", 32'(scanlines_o), 32'd2);

    // Reset mid-coin-pulse and mid-ARMING, then re-arm from IDLE.
    kbd_i = 8'h60;
    repeat (10) tick();
    check("pre_reset_coin_active", 32'(coin_o), 32'd1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    pulses = 0; first = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (combo_o === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("rearm_pulses", 32'(pulses), 32'd1);
    check_range("rearm_time", first, 64, 68);
    check("rearm_scan", 32'(scanlines_o), 32'd1);
    kbd_i = 8'h00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Parametrised input conditioner for arcade cores; successor to the per-core ad-hoc button/joystick glue.
- Synchronises and debounces N active-low physical inputs and ORs in keyboard-derived active-high inputs.
- Generates press/release pulses, a fixed-width coin pulse, and a hold-to-cycle combo that steps the scanline mode.
- Sits between the board pins / kbd_joystick and the game core's button_in and the video scanline select.

Parameters:
NUM_CH, 8, number of input channels
DEB_BITS, 10, debounce counter width; an input change is accepted after 2^DEB_BITS consecutive differing samples
COIN_CH, 5, channel index whose press triggers coin_o
COIN_PULSE, 16, coin_o high width in clk_sys cycles (>=1)
COMBO_MASK, 8'b0110_0000, channels that must be held together to trigger a combo (NUM_CH bits, nonzero)
COMBO_BITS, 20, combo hold time is 2^COMBO_BITS cycles

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
raw_n_i  in  NUM_CH  physical inputs, active low, asynchronous
kbd_i  in  NUM_CH  keyboard inputs, active high, synchronous to clk_sys
btn_o  out  NUM_CH  conditioned buttons, active high
press_o  out  NUM_CH  one-cycle pulse on btn_o rising edge
release_o  out  NUM_CH  one-cycle pulse on btn_o falling edge
coin_o  out  1  coin pulse, active high
combo_o  out  1  one-cycle pulse when a combo fires
scanlines_o  out  2  scanline mode, 0..3

Behaviour:
- Clock and reset: one clock domain, clk_sys. Reset is synchronous and active-high.
- Reset state:
  - All outputs, synchroniser flops, debounced state, counters and edge history go to 0.
  - scanlines_o = 0; combo FSM = IDLE.
  - Reset takes priority over every other event, including mid-debounce, mid-coin-pulse and mid-combo.
  - The synchroniser holds 0 during reset (i.e. raw_n_i treated as 1). An input held low through reset is therefore seen as a fresh change after reset and must debounce normally.
- Synchroniser: two-flop sync per channel on ~raw_n_i, giving s[i].
- Debounce, per channel, with stable state st[i] and counter cnt[i] (DEB_BITS wide):
  - s==st: cnt <= 0.
  - s!=st and cnt != all-ones: cnt <= cnt+1.
  - s!=st and cnt == all-ones: st <= s, cnt <= 0.
  - Net effect: st changes at the 2^DEB_BITS-th consecutive differing sample. A single agreeing sample resets the count.
- Merge: btn_o <= st | kbd_i (registered). kbd_i bypasses debounce with 1-cycle latency.
- Latency:
  - Pin edge to btn_o: 2 + 2^DEB_BITS + 1 cycles.
  - kbd_i edge to btn_o: 1 cycle.
- Edges: press_o = btn_o & ~btn_prev; release_o = ~btn_o & btn_prev; both registered, 1 cycle after the btn_o change.
- Coin:
  - When press_o[COIN_CH] is seen, coin_o goes high for exactly COIN_PULSE cycles, starting the next cycle.
  - Presses during an active pulse are ignored: no retrigger, no extension, no queueing.
  - A press in the same cycle the pulse ends is also ignored.
- Combo FSM, with all = &(btn_o | ~COMBO_MASK):
  - IDLE: all=1 -> ARMING, timer <= 0.
  - ARMING:
    - all=0 -> IDLE.
    - Otherwise timer++.
    - At timer == all-ones with all=1 -> FIRED; combo_o pulses 1 cycle; scanlines_o <= scanlines_o+1, wrapping 3->0.
  - FIRED: stays until all=0, then -> IDLE. No repeat while held.
  - press_o, release_o and btn_o for combo channels pass through unaltered; the combo does not suppress game inputs.
- Simultaneous events:
  - The coin channel may also be a combo channel; both functions operate independently.
  - Per-channel debounce is fully independent; any number of channels may update in the same cycle.

Test Plan:
- DEB_BITS=4: raw_n_i[0] driven 1->0 and held -> btn_o[0]=1 exactly 19 cycles later; press_o[0] high for 1 cycle at cycle 20; release behaves symmetrically.
- DEB_BITS=4: raw_n_i[0] low for 15 cycles, then high for 1, then low for 15 -> btn_o[0] stays 0 and press_o never asserts.
- kbd_i[3] pulsed high for 1 cycle with raw_n_i all 1 -> btn_o[3] high for 1 cycle, 1 cycle later; press_o[3] and release_o[3] each pulse once.
- COIN_PULSE=16: kbd_i[COIN_CH] pressed, released, pressed again 5 cycles later -> coin_o high exactly 16 cycles, single pulse.
- COMBO_BITS=6, COMBO_MASK=0x60: hold kbd_i[6:5] for 200 cycles -> exactly one combo_o pulse ~65 cycles after the hold starts; scanlines_o 0->1. Release and repeat 3 more times -> 2, 3, 0. Releasing bit 5 at cycle 40 of a hold -> no fire.
- Assert reset during an active coin pulse and mid-ARMING with scanlines_o=2 -> next cycle all outputs 0; a held combo re-arms from IDLE after reset deasserts.
